core_run_ctrl: RTL
==================

Name: core_run_ctrl

Overview:
- Debug run-control sequencer for the Tachyon core.
- Sits between the debug APB bridge's core-side request port and the Fetch unit.
- Decodes debug register accesses and runs a halt/resume/single-step state machine.
- Gates instruction fetch and issues PC overrides while the core is halted.

Parameters:
ADDR_WIDTH, 32, byte-address width; fetch addresses are word addresses [ADDR_WIDTH-1:2]
DBG_ADDR_WIDTH, 5, debug register address width
HALT_ON_RESET, 0, 1 = leave reset in HALTED, 0 = leave reset in RUN

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
dbg_req  in  1  debug access strobe, one cycle per access
dbg_wr_rd  in  1  1 = write, 0 = read
dbg_addr  in  DBG_ADDR_WIDTH  debug register address
dbg_wdata  in  32  write data
dbg_rdata  out  32  read data, valid while dbg_rd_ready=1
dbg_rd_ready  out  1  read-data-valid pulse
fetch_addr  in  ADDR_WIDTH-2  current fetch word address from Fetch
fetch_ack  in  1  Fetch accepted one instruction this cycle
pipe_idle  in  1  no instruction in flight past fetch
fetch_en  out  1  fetch permitted
pc_load  out  1  one-cycle pulse: Fetch loads pc_load_addr
pc_load_addr  out  ADDR_WIDTH-2  new fetch word address
halted  out  1  state == HALTED

Behaviour:
Reset (async, rst_n=0):
- state = HALTED if HALT_ON_RESET=1, else RUN.
- dbg_rdata=0, dbg_rd_ready=0, pc_load=0, pc_load_addr=0, step_cnt=0, err=0.

Register map (word addresses); writes take effect at the edge sampling dbg_req:
- 0 CTRL. Write only, bits are one-shot commands: bit0 HALT, bit1 RESUME, bit2 STEP. Reads return 0.
- 1 STATUS. Read: bit0 halted, bit1 halting, bit2 stepping, bit4 err (sticky); other bits 0. Writing 1 to bit4 clears err.
- 2 PC. Read returns {fetch_addr,2'b00}.
  - Write while HALTED: registers pc_load_addr=wdata[ADDR_WIDTH-1:2] and pulses pc_load=1 for exactly the next cycle.
  - Write in any other state: no pc_load; sets err.
- 3 STEP_CNT. Read returns {16'b0, step_cnt}. Any write clears step_cnt. step_cnt is 16 bits and wraps 0xFFFF->0.
- Unmapped addresses: reads return 0; writes are ignored and do not set err.

Read timing:
- dbg_rdata is registered. dbg_rd_ready=1 for exactly one cycle, the cycle after a read dbg_req; 0 otherwise, including after writes.
- Back-to-back reads produce back-to-back rd_ready pulses.

State machine (registered state):
- RUN: HALT -> HALTING. STEP and RESUME ignored.
- HALTING: minimum 1 cycle; -> HALTED in the first cycle pipe_idle=1. All commands ignored.
- HALTED: STEP -> STEP_FETCH; RESUME -> RUN.
- STEP_FETCH: on fetch_ack -> STEP_DRAIN. Commands ignored.
- STEP_DRAIN: on pipe_idle -> HALTED, and step_cnt increments on that transition.
- Several CTRL bits set in one write: priority HALT > STEP > RESUME. Only the highest-priority bit legal in the current state acts.

Outputs:
- fetch_en is decoded from the state register only: 1 in RUN and STEP_FETCH, 0 otherwise. There is no combinational path from any input to fetch_en.
- Exactly one fetch_ack is consumed per step. A fetch_ack while fetch_en=0 is ignored.
- halted, STATUS.halting and STATUS.stepping (STEP_FETCH or STEP_DRAIN) are all decoded from state.

Boundary cases:
- A PC write and a STEP in consecutive cycles are legal. pc_load precedes the first step fetch because STEP_FETCH is entered no earlier than the cycle after the PC write.
- rst_n asserted mid-step or mid-halt: immediate return to the reset state; step_cnt is cleared.

Test Plan:
- HALT_ON_RESET=0, release rst_n -> fetch_en=1 first cycle; read STATUS -> rd_ready pulse 1 cycle later with rdata=0x0.
- In RUN, write CTRL=0x1 with pipe_idle held 0 for 5 cycles then 1 -> fetch_en=0 the next cycle; STATUS=0x2 during the wait; halted=1 the cycle after pipe_idle rises.
- Halted, write PC=0x0000_1000 -> pc_load=1 for one cycle with pc_load_addr=0x400. Write PC while RUN -> no pc_load, STATUS bit4=1; write STATUS=0x10 -> bit4=0.
- Halted, write CTRL=0x4, fetch_ack after 3 cycles, pipe_idle 2 cycles later -> fetch_en high until ack then low; halted returns; STEP_CNT reads 1. Repeat with step_cnt preset by 0xFFFF steps (or forced) -> reads 0.
- Halted, write CTRL=0x7 -> STEP wins (HALT illegal in HALTED). In RUN, write CTRL=0x7 -> HALTING.
- Assert rst_n=0 during STEP_DRAIN -> state RUN (HALT_ON_RESET=0), step_cnt=0, pc_load=0, dbg_rd_ready=0 with no clock edge needed.

Source files
------------

// File: rtl/core_run_ctrl_if.sv
// Debug-port and fetch-side signal bundle for the run-control sequencer.
// master = debug bridge / fetch side, slave = core_run_ctrl.
interface core_run_ctrl_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DBG_ADDR_WIDTH = 5
);
  logic                      dbg_req;
  logic                      dbg_wr_rd;
  logic [DBG_ADDR_WIDTH-1:0] dbg_addr;
  logic [31:0]               dbg_wdata;
  logic [31:0]               dbg_rdata;
  logic                      dbg_rd_ready;
  logic [ADDR_WIDTH-3:0]     fetch_addr;
  logic                      fetch_ack;
  logic                      pipe_idle;
  logic                      fetch_en;
  logic                      pc_load;
  logic [ADDR_WIDTH-3:0]     pc_load_addr;
  logic                      halted;

  modport master (
    output dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata, fetch_addr, fetch_ack, pipe_idle,
    input  dbg_rdata, dbg_rd_ready, fetch_en, pc_load, pc_load_addr, halted
  );

  modport slave (
    input  dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata, fetch_addr, fetch_ack, pipe_idle,
    output dbg_rdata, dbg_rd_ready, fetch_en, pc_load, pc_load_addr, halted
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Debug run-control sequencer: decodes debug register accesses and runs the
// halt / resume / single-step state machine that gates instruction fetch.
module core_run_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DBG_ADDR_WIDTH = 5,
  parameter bit          HALT_ON_RESET  = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  core_run_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StRun,
    StHalting,
    StHalted,
    StStepFetch,
    StStepDrain
  } state_e;

  localparam state_e ResetState = HALT_ON_RESET ? StHalted : StRun;

  localparam logic [DBG_ADDR_WIDTH-1:0] AddrCtrl    = DBG_ADDR_WIDTH'(0);
  localparam logic [DBG_ADDR_WIDTH-1:0] AddrStatus  = DBG_ADDR_WIDTH'(1);
  localparam logic [DBG_ADDR_WIDTH-1:0] AddrPc      = DBG_ADDR_WIDTH'(2);
  localparam logic [DBG_ADDR_WIDTH-1:0] AddrStepCnt = DBG_ADDR_WIDTH'(3);

  state_e                state_q, state_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rd_ready_q, rd_ready_d;
  logic                  pc_load_q, pc_load_d;
  logic [ADDR_WIDTH-3:0] pc_addr_q, pc_addr_d;
  logic [15:0]           step_cnt_q, step_cnt_d;
  logic                  err_q, err_d;

  logic wr_en, rd_en;
  logic wr_ctrl, wr_status, wr_pc, wr_step_cnt;
  logic cmd_halt, cmd_resume, cmd_step;
  logic is_halted, is_halting, is_stepping;
  logic step_done;
  logic [31:0] status;

  assign wr_en       = bus.dbg_req & bus.dbg_wr_rd;
  assign rd_en       = bus.dbg_req & ~bus.dbg_wr_rd;
  assign wr_ctrl     = wr_en && (bus.dbg_addr == AddrCtrl);
  assign wr_status   = wr_en && (bus.dbg_addr == AddrStatus);
  assign wr_pc       = wr_en && (bus.dbg_addr == AddrPc);
  assign wr_step_cnt = wr_en && (bus.dbg_addr == AddrStepCnt);

  assign cmd_halt    = wr_ctrl & bus.dbg_wdata[0];
  assign cmd_resume  = wr_ctrl & bus.dbg_wdata[1];
  assign cmd_step    = wr_ctrl & bus.dbg_wdata[2];

  assign is_halted   = (state_q == StHalted);
  assign is_halting  = (state_q == StHalting);
  assign is_stepping = (state_q == StStepFetch) || (state_q == StStepDrain);
  assign status      = {27'b0, err_q, 1'b0, is_stepping, is_halting, is_halted};

  // Commands outside their legal state fall through, so HALT > STEP > RESUME
  // resolves naturally: HALT only matters in RUN, STEP/RESUME only in HALTED.
  always_comb begin
    state_d   = state_q;
    step_done = 1'b0;
    unique case (state_q)
      StRun:       if (cmd_halt) state_d = StHalting;
      StHalting:   if (bus.pipe_idle) state_d = StHalted;
      StHalted: begin
        if (cmd_step) begin
          state_d = StStepFetch;
        end else if (cmd_resume) begin
          state_d = StRun;
        end
      end
      StStepFetch: if (bus.fetch_ack) state_d = StStepDrain;
      StStepDrain: begin
        if (bus.pipe_idle) begin
          state_d   = StHalted;
          step_done = 1'b1;
        end
      end
      default:     state_d = ResetState;
    endcase
  end

  always_comb begin
    rd_ready_d = rd_en;
    rdata_d    = rdata_q;
    if (rd_en) begin
      case (bus.dbg_addr)
        AddrCtrl:    rdata_d = '0;
        AddrStatus:  rdata_d = status;
        AddrPc:      rdata_d = 32'({bus.fetch_addr, 2'b00});
        AddrStepCnt: rdata_d = {16'b0, step_cnt_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    pc_load_d  = 1'b0;
    pc_addr_d  = pc_addr_q;
    err_d      = err_q;
    step_cnt_d = step_cnt_q + 16'(step_done);
    if (wr_pc) begin
      if (is_halted) begin
        pc_load_d = 1'b1;
        pc_addr_d = bus.dbg_wdata[ADDR_WIDTH-1:2];
      end else begin
        err_d = 1'b1;
      end
    end
    if (wr_status && bus.dbg_wdata[4]) err_d = 1'b0;
    // A clear coinciding with a step completion wins.
    if (wr_step_cnt) step_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ResetState;
      rdata_q    <= '0;
      rd_ready_q <= 1'b0;
      pc_load_q  <= 1'b0;
      pc_addr_q  <= '0;
      step_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      rd_ready_q <= rd_ready_d;
      pc_load_q  <= pc_load_d;
      pc_addr_q  <= pc_addr_d;
      step_cnt_q <= step_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.dbg_rdata    = rdata_q;
  assign bus.dbg_rd_ready = rd_ready_q;
  assign bus.pc_load      = pc_load_q;
  assign bus.pc_load_addr = pc_addr_q;
  assign bus.fetch_en     = (state_q == StRun) || (state_q == StStepFetch);
  assign bus.halted       = is_halted;

endmodule
